mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester (instruction and data ports) and mem_responder.
interface mem_responder_if #(
    parameter int WORD_W = 16
);
    logic              i_readM;
    logic [WORD_W-1:0] i_address;
    logic [WORD_W-1:0] i_data;
    logic              i_inputReady;
    logic              d_readM;
    logic              d_writeM;
    logic [WORD_W-1:0] d_address;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_inputReady;
    logic              d_ack;
    logic              err;

    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
        input  i_data, i_inputReady, d_rdata, d_inputReady, d_ack, err
    );

    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
        output i_data, i_inputReady, d_rdata, d_inputReady, d_ack, err
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder serving one instruction-read or data-read/write at a time.
// Priority d_writeM > d_readM > i_readM; one transaction per LATENCY+2 cycles.
module mem_responder #(
    parameter int WORD_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_IREAD  = 2'd0,
        K_DREAD  = 2'd1,
        K_DWRITE = 2'd2
    } kind_t;

    // Any address bit above the array index marks the access as out of range.
    function automatic logic addr_oob(input logic [WORD_W-1:0] addr);
        return (addr >> IDX_W) != {WORD_W{1'b0}};
    endfunction

    state_t            r_state;
    logic [3:0]        r_cnt;
    kind_t             r_kind;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_oob;
    logic [WORD_W-1:0] r_i_data;
    logic [WORD_W-1:0] r_d_rdata;
    logic              r_i_rdy;
    logic              r_d_rdy;
    logic              r_d_ack;
    logic              r_err;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_req_any;
    logic              w_conflict;
    kind_t             w_sel_kind;
    logic [WORD_W-1:0] w_sel_addr;
    logic              w_done;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_rword;

    // Fixed-priority selection among pending requests.
    always_comb begin
        w_req_any  = bus.d_writeM | bus.d_readM | bus.i_readM;
        w_conflict = bus.d_writeM & bus.d_readM;
        w_sel_kind = K_IREAD;
        w_sel_addr = bus.i_address;
        if (bus.d_writeM) begin
            w_sel_kind = K_DWRITE;
            w_sel_addr = bus.d_address;
        end else if (bus.d_readM) begin
            w_sel_kind = K_DREAD;
            w_sel_addr = bus.d_address;
        end else begin
            w_sel_kind = K_IREAD;
            w_sel_addr = bus.i_address;
        end
    end

    // Completion strobe and array access for the latched transaction.
    always_comb begin
        w_done   = (r_state == S_BUSY) && (r_cnt == 4'd0);
        w_mem_we = w_done && (r_kind == K_DWRITE) && !r_oob;
        w_rword  = r_oob ? {WORD_W{1'b0}} : r_mem[r_idx];
    end

    // Transaction FSM with registered data and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_kind    <= K_IREAD;
            r_idx     <= {IDX_W{1'b0}};
            r_wdata   <= {WORD_W{1'b0}};
            r_oob     <= 1'b0;
            r_i_data  <= {WORD_W{1'b0}};
            r_d_rdata <= {WORD_W{1'b0}};
            r_i_rdy   <= 1'b0;
            r_d_rdy   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i_rdy <= 1'b0;
                    r_d_rdy <= 1'b0;
                    r_d_ack <= 1'b0;
                    if (w_req_any) begin
                        r_kind  <= w_sel_kind;
                        r_idx   <= w_sel_addr[IDX_W-1:0];
                        r_wdata <= bus.d_wdata;
                        r_oob   <= addr_oob(w_sel_addr);
                        r_cnt   <= CNT_LOAD;
                        r_err   <= r_err | w_conflict | addr_oob(w_sel_addr);
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        case (r_kind)
                            K_IREAD: begin
                                r_i_data <= w_rword;
                                r_i_rdy  <= 1'b1;
                            end
                            K_DREAD: begin
                                r_d_rdata <= w_rword;
                                r_d_rdy   <= 1'b1;
                            end
                            default: begin
                                r_d_ack <= 1'b1;
                            end
                        endcase
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_i_rdy <= 1'b0;
                    r_d_rdy <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_i_rdy <= 1'b0;
                    r_d_rdy <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.i_data       = r_i_data;
    assign bus.i_inputReady = r_i_rdy;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_inputReady = r_d_rdy;
    assign bus.d_ack        = r_d_ack;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-timeline model checked every cycle, directed and random traffic.
module tb_mem_responder;
    localparam int W = 16;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.WORD_W(W)) bus ();
    mem_responder_if #(.WORD_W(W)) bus1 ();

    mem_responder #(.WORD_W(W), .DEPTH(256), .LATENCY(L)) u_dut (.clk(clk), .reset(rst), .bus(bus));
    mem_responder #(.WORD_W(W), .DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .reset(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: memory image plus a timeline of accept/ack edges.
    logic [15:0] m_mem [256];
    logic [15:0] m_idata, m_drdata, m_addr, m_wd;
    logic        m_pi, m_pdr, m_pda, m_err, m_busy, m_oob;
    int          m_kind, m_ack_at, m_next_ok;

    function automatic void model_reset();
        m_idata = 16'h0; m_drdata = 16'h0; m_err = 1'b0;
        m_pi = 1'b0; m_pdr = 1'b0; m_pda = 1'b0; m_busy = 1'b0;
        m_next_ok = cyc + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                model_reset();
            end else begin
                m_pi = 1'b0; m_pdr = 1'b0; m_pda = 1'b0;
                if (m_busy && cyc == m_ack_at) begin
                    m_oob = (m_addr[15:8] != 8'h00);
                    if (m_kind == 0) begin
                        m_idata = m_oob ? 16'h0 : m_mem[m_addr[7:0]];
                        m_pi = 1'b1;
                    end else if (m_kind == 1) begin
                        m_drdata = m_oob ? 16'h0 : m_mem[m_addr[7:0]];
                        m_pdr = 1'b1;
                    end else begin
                        if (!m_oob) m_mem[m_addr[7:0]] = m_wd;
                        m_pda = 1'b1;
                    end
                    m_busy = 1'b0;
                end else if (!m_busy && cyc >= m_next_ok) begin
                    m_busy = 1'b1;
                    if (bus.d_writeM) begin
                        m_kind = 2; m_addr = bus.d_address; m_wd = bus.d_wdata;
                        if (bus.d_readM) m_err = 1'b1;
                    end else if (bus.d_readM) begin
                        m_kind = 1; m_addr = bus.d_address;
                    end else if (bus.i_readM) begin
                        m_kind = 0; m_addr = bus.i_address;
                    end else begin
                        m_busy = 1'b0;
                    end
                    if (m_busy) begin
                        m_ack_at  = cyc + L;
                        m_next_ok = cyc + L + 2;
                        if (m_addr[15:8] != 8'h00) m_err = 1'b1;
                    end
                end
            end
            @(negedge clk);
            if (rst) model_reset();
            chk("i_inputReady", bus.i_inputReady, m_pi);
            chk("d_inputReady", bus.d_inputReady, m_pdr);
            chk("d_ack", bus.d_ack, m_pda);
            chk("err", bus.err, m_err);
            chk("i_data", bus.i_data, m_idata);
            chk("d_rdata", bus.d_rdata, m_drdata);
        end
    end

    task automatic d_txn(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output logic [15:0] rdv, output int pc);
        int n;
        @(posedge clk); #1;
        bus.d_writeM = wr; bus.d_readM = rd; bus.d_address = a; bus.d_wdata = wd;
        n = cyc; lat = -1; pc = -1; rdv = 16'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.d_ack || bus.d_inputReady) begin
                pc = cyc; lat = cyc - (n + 1); rdv = bus.d_rdata;
                break;
            end
        end
        if (pc < 0) chk("d_txn_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.d_writeM = 1'b0; bus.d_readM = 1'b0;
    endtask

    task automatic i_txn(input logic [15:0] a, output logic [15:0] rdv, output int pc);
        @(posedge clk); #1;
        bus.i_readM = 1'b1; bus.i_address = a;
        pc = -1; rdv = 16'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.i_inputReady) begin
                pc = cyc; rdv = bus.i_data;
                break;
            end
        end
        if (pc < 0) chk("i_txn_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.i_readM = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom_range(0, 31));
        if ($urandom_range(0, 15) == 0) a = a | 16'h0400;
        return a;
    endfunction

    task automatic drv_d(input int n);
        int gap, r;
        logic seen;
        @(posedge clk); #1;
        for (int t = 0; t < n; t++) begin
            r = $urandom_range(0, 9);
            bus.d_writeM = (r <= 4); bus.d_readM = (r == 0) || (r > 4);
            bus.d_address = rand_addr(); bus.d_wdata = 16'($urandom);
            seen = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (bus.d_ack || bus.d_inputReady) begin seen = 1'b1; break; end
            end
            if (!seen) begin
                chk("d_drv_timeout", 32'd0, 32'd1);
                bus.d_writeM = 1'b0; bus.d_readM = 1'b0;
                return;
            end
            @(posedge clk); #1;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                bus.d_writeM = 1'b0; bus.d_readM = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        bus.d_writeM = 1'b0; bus.d_readM = 1'b0;
    endtask

    task automatic drv_i(input int n);
        int gap;
        logic seen;
        @(posedge clk); #1;
        for (int t = 0; t < n; t++) begin
            bus.i_readM = 1'b1; bus.i_address = rand_addr();
            seen = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (bus.i_inputReady) begin seen = 1'b1; break; end
            end
            if (!seen) begin
                chk("i_drv_timeout", 32'd0, 32'd1);
                bus.i_readM = 1'b0;
                return;
            end
            @(posedge clk); #1;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                bus.i_readM = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        bus.i_readM = 1'b0;
    endtask

    initial begin
        int lat, pc, ipc, dpc, cnt, last, k;
        logic [15:0] rdv, irdv;
        bus.i_readM = 1'b0; bus.i_address = 16'h0; bus.d_readM = 1'b0; bus.d_writeM = 1'b0;
        bus.d_address = 16'h0; bus.d_wdata = 16'h0;
        bus1.i_readM = 1'b0; bus1.i_address = 16'h0; bus1.d_readM = 1'b0; bus1.d_writeM = 1'b0;
        bus1.d_address = 16'h0; bus1.d_wdata = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_data", bus.i_data, 16'h0);
        chk("rst_d_rdata", bus.d_rdata, 16'h0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_pulses", {bus.i_inputReady, bus.d_inputReady, bus.d_ack}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int a = 0; a < 256; a++) d_txn(1'b1, 1'b0, 16'(a), 16'($urandom), lat, rdv, pc);

        d_txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, lat, rdv, pc);
        chk("wr_latency", lat, 2);
        d_txn(1'b0, 1'b1, 16'h0010, 16'h0000, lat, rdv, pc);
        chk("rd_latency", lat, 2);
        chk("rd_beef", rdv, 16'hBEEF);

        fork
            d_txn(1'b0, 1'b1, 16'h0010, 16'h0000, lat, rdv, dpc);
            i_txn(16'h0010, irdv, ipc);
        join
        chk("arb_spacing", ipc - dpc, 4);
        chk("arb_i_data", irdv, 16'hBEEF);
        @(negedge clk);
        chk("arb_err", bus.err, 1'b0);

        for (int a = 0; a < 4; a++) begin
            @(posedge clk); #1;
            bus1.d_writeM = 1'b1; bus1.d_address = 16'(a); bus1.d_wdata = 16'hC000 + 16'(a);
            cnt = 0;
            while (!bus1.d_ack && cnt < 20) begin @(negedge clk); cnt++; end
            chk("l1_wr_ack", bus1.d_ack, 1'b1);
            @(posedge clk); #1;
            bus1.d_writeM = 1'b0;
        end
        @(posedge clk); #1;
        bus1.i_readM = 1'b1; bus1.i_address = 16'h0;
        k = 0; last = -1;
        for (int t = 0; t < 40 && k < 4; t++) begin
            @(negedge clk);
            if (bus1.i_inputReady) begin
                chk("l1_i_data", bus1.i_data, 16'hC000 + 16'(k));
                if (k > 0) chk("l1_spacing", cyc - last, 3);
                last = cyc; k++;
                @(posedge clk); #1;
                bus1.i_address = 16'(k);
                if (k == 4) bus1.i_readM = 1'b0;
            end
        end
        bus1.i_readM = 1'b0;
        chk("l1_count", k, 4);

        d_txn(1'b0, 1'b1, 16'h0000, 16'h0, lat, rdv, pc);
        irdv = rdv;
        d_txn(1'b1, 1'b0, 16'h0100, 16'hDEAD, lat, rdv, pc);
        chk("oob_ack_latency", lat, 2);
        @(negedge clk);
        chk("oob_err", bus.err, 1'b1);
        d_txn(1'b0, 1'b1, 16'h0000, 16'h0, lat, rdv, pc);
        chk("oob_no_alias", rdv, irdv);
        chk("oob_err_sticky", bus.err, 1'b1);

        d_txn(1'b1, 1'b1, 16'h0005, 16'h1234, lat, rdv, pc);
        chk("both_ack_latency", lat, 2);
        d_txn(1'b0, 1'b1, 16'h0005, 16'h0, lat, rdv, pc);
        chk("both_rd", rdv, 16'h1234);
        chk("both_err", bus.err, 1'b1);

        d_txn(1'b1, 1'b0, 16'h0003, 16'h5A5A, lat, rdv, pc);
        @(posedge clk); #1;
        bus.d_writeM = 1'b1; bus.d_address = 16'h0003; bus.d_wdata = 16'hAAAA;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {bus.i_data, bus.d_rdata, bus.err, bus.d_ack}, 34'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.d_writeM = 1'b0;
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (bus.d_ack) cnt++; end
        chk("abort_no_ack", cnt, 0);
        d_txn(1'b0, 1'b1, 16'h0003, 16'h0, lat, rdv, pc);
        chk("abort_prior", rdv, 16'h5A5A);

        fork
            drv_d(150);
            drv_i(150);
        join
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
